// File: rtl/fb_fill_writer.sv
// rtl/fb_fill_writer.sv - ping-pong frame RAM fill writer
// Purpose: on each frame_start, walks the XMAX x YSPAN RAM-resident play area
//   column by column (y fastest), asks the combinational color source for each
//   pixel and writes it into the back buffer, then hands that buffer to the
//   reader through buf_sel.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   frame_start    one-cycle fill request
//   xpos, ypos     coordinate of the next pixel for the color source
//   color_in       color for xpos/ypos, same cycle
//   wr_en/wr_ready write handshake; wr_addr = x*YSPAN + y, wr_data = color
//   buf_sel        back-buffer select (reader uses ~buf_sel)
//   busy, done     fill in progress / one-cycle completion pulse
//   overrun        sticky: frame_start seen while busy or on the done cycle
// Optional: define FB_FILL_CHECKSUM_EN to add frame_sum, the modulo-2^16 sum
//   of all accepted wr_data of the last completed frame.
module fb_fill_writer #(
  parameter int XMAX    = 240,
  parameter int YSPAN   = 264,
  parameter int YOFFSET = 24,
  parameter int ADDR_W  = 16,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  output logic [9:0]         xpos,
  output logic [9:0]         ypos,
  input  logic [COLOR_W-1:0] color_in,
  output logic               wr_en,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               buf_sel,
  output logic               busy,
  output logic               done,
  output logic               overrun
`ifdef FB_FILL_CHECKSUM_EN
  ,
  output logic [15:0]        frame_sum
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [9:0] XLAST = 10'(XMAX - 1);
  localparam logic [9:0] YLAST = 10'(YSPAN - 1);
  localparam logic [9:0] YOFF  = 10'(YOFFSET);

  state_t            state, state_nxt;
  logic [9:0]        x_cnt, y_cnt;
  logic [ADDR_W-1:0] lin_cnt;   // running x*YSPAN + y, avoids a multiplier
  logic              started;   // a buffer has been filled since reset
  logic              load, start_ok, finish, last_pix;

  assign xpos     = x_cnt;
  assign ypos     = y_cnt + YOFF;
  assign last_pix = (x_cnt == XLAST) && (y_cnt == YLAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok)        state_nxt = ST_FILL;
      ST_FILL:  if (load && last_pix) state_nxt = ST_DRAIN;
      ST_DRAIN: if (wr_ready)        state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode. A start request on the done cycle is dropped:
  // the pulse is treated as having arrived while still busy.
  always_comb begin
    busy     = (state != ST_IDLE);
    load     = (state == ST_FILL) && (!wr_en || wr_ready);
    start_ok = (state == ST_IDLE) && frame_start && !done;
    finish   = (state == ST_DRAIN) && wr_ready;  // wr_en is always high in DRAIN
  end

  // Counters and the single output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      lin_cnt <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      buf_sel <= 1'b0;
      started <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= finish;
      if (frame_start && (busy || done)) overrun <= 1'b1;

      if (start_ok) begin
        x_cnt   <= '0;
        y_cnt   <= '0;
        lin_cnt <= '0;
        started <= 1'b1;
        // The first fill after reset has no valid front buffer to swap from.
        if (started) buf_sel <= ~buf_sel;
      end

      if (load) begin
        wr_en   <= 1'b1;
        wr_data <= color_in;
        wr_addr <= lin_cnt;
        lin_cnt <= lin_cnt + 1'b1;
        if (y_cnt == YLAST) begin
          y_cnt <= '0;
          x_cnt <= (x_cnt == XLAST) ? '0 : x_cnt + 1'b1;
        end else begin
          y_cnt <= y_cnt + 1'b1;
        end
      end else if (finish) begin
        wr_en <= 1'b0;
      end
    end
  end

`ifdef FB_FILL_CHECKSUM_EN
  logic [15:0] sum_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_run   <= '0;
      frame_sum <= '0;
    end else begin
      if (start_ok)              sum_run <= '0;
      else if (wr_en && wr_ready) sum_run <= sum_run + 16'(wr_data);
      // The final accepted write is folded in on the same edge done rises.
      if (finish) frame_sum <= sum_run + 16'(wr_data);
    end
  end
`endif

endmodule

// File: tb/tb_fb_fill_writer.sv
// tb/tb_fb_fill_writer.sv - self-checking bench for fb_fill_writer
module tb_fb_fill_writer;

  localparam int XMAX    = 240;
  localparam int YSPAN   = 264;
  localparam int YOFFSET = 24;
  localparam int TOTAL   = XMAX * YSPAN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, frame_start, wr_ready;
  logic [9:0]  xpos, ypos;
  logic [7:0]  color_in, key;
  logic        wr_en, buf_sel, busy, done, overrun;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
`ifdef FB_FILL_CHECKSUM_EN
  logic [15:0] frame_sum;
`endif

  // Combinational color source: coordinate nibbles, optionally scrambled by key
  assign color_in = {xpos[3:0], ypos[3:0]} ^ key;

  fb_fill_writer #(
    .XMAX(XMAX), .YSPAN(YSPAN), .YOFFSET(YOFFSET), .ADDR_W(16), .COLOR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .xpos(xpos), .ypos(ypos), .color_in(color_in),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .buf_sel(buf_sel), .busy(busy), .done(done), .overrun(overrun)
`ifdef FB_FILL_CHECKSUM_EN
    , .frame_sum(frame_sum)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Fill scenario knobs and results
  int stall_addr, stall_len, rand_lo, rand_hi, stray_at, drain_stall, abort_at;
  int writes, stalls, first_wr_cyc, done_cyc;
  logic [15:0] model_sum;

  // Expected pixel for linear address a: column-major walk, y fastest
  function automatic logic [7:0] ref_color(input int a, input logic [7:0] k);
    int xv, yv;
    xv = a / YSPAN;
    yv = (a % YSPAN) + YOFFSET;
    return {xv[3:0], yv[3:0]} ^ k;
  endfunction

  task automatic start_frame(input logic exp_buf);
    @(negedge clk);
    frame_start = 1'b1;
    wr_ready    = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    tests++;
    if (busy !== 1'b1 || wr_en !== 1'b0 || buf_sel !== exp_buf ||
        xpos !== 10'd0 || ypos !== 10'(YOFFSET))
      begin
        fails++;
        $display("FAIL fill_entry: busy=%b wr_en=%b buf_sel=%b xpos=%0d ypos=%0d, want 1 0 %b 0 %0d",
                 busy, wr_en, buf_sel, xpos, ypos, exp_buf, YOFFSET);
      end
  endtask

  task automatic run_fill();
    int cyc = 0;
    int stall_left = stall_len;
    int drain_left = drain_stall;
    logic prev_hold = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    logic stray_sent = 1'b0;
    logic rdy;
    writes = 0; stalls = 0; first_wr_cyc = -1; done_cyc = -1; model_sum = '0;
    while (cyc < 70000) begin
      @(negedge clk);
      cyc++;
      frame_start = 1'b0;
      if (prev_hold) begin
        tests++;
        if (wr_en !== 1'b1 || wr_addr !== prev_addr || wr_data !== prev_data) begin
          fails++;
          $display("FAIL stall_hold cyc=%0d: en=%b addr=%0d data=%h, want en=1 addr=%0d data=%h",
                   cyc, wr_en, wr_addr, wr_data, prev_addr, prev_data);
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (wr_en === 1'b1 && first_wr_cyc < 0) first_wr_cyc = cyc;
      rdy = 1'b1;
      if (wr_en === 1'b1) begin
        if (wr_addr == stall_addr && stall_left > 0) begin
          rdy = 1'b0; stall_left--;
        end else if (wr_addr == TOTAL - 1 && drain_left > 0) begin
          rdy = 1'b0; drain_left--;
        end else if (writes >= rand_lo && writes < rand_hi) begin
          rdy = 1'($urandom_range(0, 1));
        end
      end
      wr_ready = rdy;
      if (stray_at >= 0 && !stray_sent && writes == stray_at) begin
        frame_start = 1'b1;
        stray_sent  = 1'b1;
      end
      if (wr_en === 1'b1) begin
        if (rdy) begin
          tests++;
          if (wr_addr !== 16'(writes) || wr_data !== ref_color(writes, key)) begin
            fails++;
            $display("FAIL write #%0d: addr=%0d data=%h, want addr=%0d data=%h",
                     writes, wr_addr, wr_data, writes, ref_color(writes, key));
          end
          model_sum = model_sum + 16'(ref_color(writes, key));
          writes++;
        end else begin
          stalls++;
        end
      end
      prev_hold = (wr_en === 1'b1) && !rdy;
      prev_addr = wr_addr;
      prev_data = wr_data;
      if (fails > 40) break;
      if (abort_at >= 0 && writes == abort_at) break;
    end
    if (abort_at < 0) begin
      tests++;
      if (done_cyc < 0) begin
        fails++;
        $display("FAIL done_timeout: no done pulse, writes=%0d want %0d", writes, TOTAL);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; frame_start = 1'b0; wr_ready = 1'b0; key = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 ||
        buf_sel !== 1'b0 || wr_addr !== 16'd0 || wr_data !== 8'd0 ||
        xpos !== 10'd0 || ypos !== 10'(YOFFSET))
      begin
        fails++;
        $display("FAIL reset_state: en=%b busy=%b done=%b ovr=%b buf=%b addr=%0d data=%h x=%0d y=%0d",
                 wr_en, busy, done, overrun, buf_sel, wr_addr, wr_data, xpos, ypos);
      end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: busy=%b wr_en=%b, want 0 0", busy, wr_en);
    end
  endtask

  task automatic test_first_frame();
    key = 8'h00;
    stall_addr = 100; stall_len = 5; rand_lo = 2000; rand_hi = 2600;
    stray_at = -1; drain_stall = 3; abort_at = -1;
    start_frame(1'b0);
    run_fill();
    tests++;
    if (first_wr_cyc != 1) begin
      fails++;
      $display("FAIL first_latency: first wr_en at cycle %0d, want 1", first_wr_cyc);
    end
    tests++;
    if (writes != TOTAL) begin
      fails++;
      $display("FAIL frame_writes: %0d writes, want %0d", writes, TOTAL);
    end
    tests++;
    if (done_cyc - first_wr_cyc != TOTAL + stalls) begin
      fails++;
      $display("FAIL done_timing: %0d cycles, want %0d", done_cyc - first_wr_cyc, TOTAL + stalls);
    end
`ifdef FB_FILL_CHECKSUM_EN
    tests++;
    if (frame_sum !== model_sum) begin
      fails++;
      $display("FAIL frame_sum: %h, want %h", frame_sum, model_sum);
    end
`endif
    tests++;
    if (overrun !== 1'b0 || buf_sel !== 1'b0) begin
      fails++;
      $display("FAIL frame1_flags: overrun=%b buf_sel=%b, want 0 0", overrun, buf_sel);
    end
    // frame_start on the done cycle is lost and flagged
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1 || wr_en !== 1'b0 || buf_sel !== 1'b0) begin
      fails++;
      $display("FAIL done_cycle_start: done=%b busy=%b ovr=%b en=%b buf=%b, want 0 0 1 0 0",
               done, busy, overrun, wr_en, buf_sel);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL done_cycle_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_toggle_and_reset();
    key = 8'($urandom);
    stall_addr = -1; stall_len = 0; rand_lo = 300; rand_hi = 1300;
    stray_at = 1000; drain_stall = 0; abort_at = 5000;
    start_frame(1'b1);
    run_fill();
    tests++;
    if (writes != 5000 || busy !== 1'b1 || buf_sel !== 1'b1) begin
      fails++;
      $display("FAIL frame2_progress: writes=%0d busy=%b buf=%b, want 5000 1 1", writes, busy, buf_sel);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || buf_sel !== 1'b0 || overrun !== 1'b0 || wr_addr !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: en=%b busy=%b buf=%b ovr=%b addr=%0d, want 0 0 0 0 0",
               wr_en, busy, buf_sel, overrun, wr_addr);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_restart_overrun();
    key = 8'($urandom);
    stall_addr = -1; stall_len = 0; rand_lo = 0; rand_hi = 400;
    stray_at = 100; drain_stall = 0; abort_at = 400;
    start_frame(1'b0);
    run_fill();
    tests++;
    if (first_wr_cyc != 1 || writes != 400) begin
      fails++;
      $display("FAIL restart: first_wr=%0d writes=%0d, want 1 400", first_wr_cyc, writes);
    end
    tests++;
    if (overrun !== 1'b1 || buf_sel !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stray_start: ovr=%b buf=%b busy=%b, want 1 0 1", overrun, buf_sel, busy);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_toggle_and_reset();
    test_restart_overrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
